boot_sequencer: RTL

- Sequences the boot flow of the processor.
- Out of reset, the CPU fetches from the BIOS ROM. When the BIOS program executes its halt, this block stalls the CPU and copies a length-prefixed program from disk storage into instruction memory.
- It then forces PC to 0 and switches instruction fetch to instruction memory (user mode).
- Sits between the control unit, PC register, BIOS/instruction-memory fetch mux, disk controller and instruction memory.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/boot_sequencer_hd_read_port.sv | 60 ++++++
 rtl/boot_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the boot path: state encoding, halt opcode and
// default instruction-memory geometry.
package cpu_pkg;

    localparam int CPU_PC_W     = 26;
    localparam int CPU_IM_DEPTH = 1024;

    localparam logic [5:0] OPC_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ST_BIOS_RUN,
        ST_REQ_LEN,
        ST_CHECK,
        ST_REQ_WORD,
        ST_WRITE,
        ST_RELEASE,
        ST_USER_RUN,
        ST_ERROR
    } boot_state_e;

endpackage

// File: rtl/boot_sequencer_hd_read_port.sv
// Single-outstanding disk read: holds hd_req/hd_addr until ack, and flags a
// timeout when the request sits unacknowledged for TIMEOUT cycles.
module hd_read_port #(
    parameter int HD_ADDR_W = 20,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [HD_ADDR_W-1:0] addr,
    output logic                 done,
    output logic [31:0]          data,
    output logic                 timeout,
    output logic                 hd_req,
    output logic [HD_ADDR_W-1:0] hd_addr,
    input  logic                 hd_ack,
    input  logic [31:0]          hd_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic                 req_q, req_d;
    logic [HD_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Ack in the final counted cycle still completes the read.
    always_comb begin
        done    = req_q & hd_ack;
        timeout = req_q & ~hd_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (start) begin
            req_d  = 1'b1;
            addr_d = addr;
            cnt_d  = '0;
        end else if (done || timeout) begin
            req_d = 1'b0;
        end else if (req_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign data    = hd_data;
    assign hd_req  = req_q;
    assign hd_addr = addr_q;

endmodule

// File: rtl/boot_sequencer.sv
// Boot flow: run BIOS until halt, copy a length-prefixed program from disk
// into instruction memory, then restart the CPU at PC 0 in user mode.
module boot_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W      = CPU_PC_W,
    parameter int IM_DEPTH  = CPU_IM_DEPTH,
    parameter int HD_ADDR_W = 20,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_halt,
    input  logic [HD_ADDR_W-1:0] hd_base,
    output logic                 bios_mode,
    output logic                 cpu_stall,
    output logic                 pc_load,
    output logic [PC_W-1:0]      pc_load_value,
    output logic                 hd_req,
    output logic [HD_ADDR_W-1:0] hd_addr,
    input  logic                 hd_ack,
    input  logic [31:0]          hd_data,
    output logic                 im_we,
    output logic [PC_W-1:0]      im_addr,
    output logic [31:0]          im_wdata,
    output logic                 boot_done,
    output logic                 boot_error
);

    boot_state_e          state_q, state_d;
    logic [HD_ADDR_W-1:0] base_q, base_d;
    logic [31:0]          len_q, len_d;
    logic [31:0]          idx_q, idx_d;
    logic [31:0]          idx_inc;
    logic [PC_W-1:0]      im_addr_q, im_addr_d;
    logic [31:0]          im_wdata_q, im_wdata_d;

    logic                 rd_start;
    logic [HD_ADDR_W-1:0] rd_addr;
    logic                 rd_done;
    logic                 rd_timeout;
    logic [31:0]          rd_data;

    hd_read_port #(
        .HD_ADDR_W (HD_ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) u_rd (
        .clock   (clock),
        .reset   (reset),
        .start   (rd_start),
        .addr    (rd_addr),
        .done    (rd_done),
        .data    (rd_data),
        .timeout (rd_timeout),
        .hd_req  (hd_req),
        .hd_addr (hd_addr),
        .hd_ack  (hd_ack),
        .hd_data (hd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BIOS_RUN;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
        end
    end

    assign idx_inc = idx_q + 32'd1;

    // The read for the next state is launched on the transition edge so that
    // hd_req is already high in the first cycle of a REQ state.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        rd_start   = 1'b0;
        rd_addr    = base_q;
        case (state_q)
            ST_BIOS_RUN: if (cpu_halt) begin
                base_d   = hd_base;
                rd_start = 1'b1;
                rd_addr  = hd_base;
                state_d  = ST_REQ_LEN;
            end
            ST_REQ_LEN: begin
                if (rd_done) begin
                    len_d   = rd_data;
                    state_d = ST_CHECK;
                end else if (rd_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_CHECK: begin
                if (len_q == 32'd0 || len_q > 32'(IM_DEPTH)) begin
                    state_d = ST_ERROR;
                end else begin
                    idx_d    = '0;
                    rd_start = 1'b1;
                    rd_addr  = base_q + HD_ADDR_W'(1);
                    state_d  = ST_REQ_WORD;
                end
            end
            ST_REQ_WORD: begin
                if (rd_done) begin
                    im_wdata_d = rd_data;
                    im_addr_d  = PC_W'(idx_q);
                    state_d    = ST_WRITE;
                end else if (rd_timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WRITE: begin
                if (idx_q == len_q - 32'd1) begin
                    state_d = ST_RELEASE;
                end else begin
                    idx_d    = idx_inc;
                    rd_start = 1'b1;
                    rd_addr  = base_q + HD_ADDR_W'(1) + idx_inc[HD_ADDR_W-1:0];
                    state_d  = ST_REQ_WORD;
                end
            end
            ST_RELEASE: state_d = ST_USER_RUN;
            default: ;
        endcase
    end

    always_comb begin
        bios_mode  = !(state_q == ST_RELEASE || state_q == ST_USER_RUN);
        cpu_stall  = !(state_q == ST_BIOS_RUN || state_q == ST_USER_RUN);
        pc_load    = (state_q == ST_RELEASE);
        im_we      = (state_q == ST_WRITE);
        boot_done  = (state_q == ST_USER_RUN);
        boot_error = (state_q == ST_ERROR);
    end

    assign pc_load_value = '0;
    assign im_addr       = im_addr_q;
    assign im_wdata      = im_wdata_q;

endmodule
